// File: rtl/soc_rst_pkg.sv
// soc_rst_pkg: shared state encoding and index-width helper for the reset/boot sequencer
package soc_rst_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_CFG   = 3'd1,
    WAIT_LOCK = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    SOFT_RST  = 3'd5,
    HALT      = 3'd6
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_release_chain.sv
// rst_release_chain: releases a loaded mask of domains one at a time, lowest index first, RELEASE_DLY cycles apart
module rst_release_chain
  import soc_rst_pkg::*;
#(
  parameter int NB          = 3,
  parameter int CNT_WIDTH   = 8,
  parameter int RELEASE_DLY = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [NB-1:0] mask_i,
  output logic [NB-1:0] rel_o,
  output logic          done_o
);

  localparam int IW = idx_w(NB);
  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(RELEASE_DLY - 1);

  logic [NB-1:0]        pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]        idx;

  always_comb begin
    idx = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (pend_q[i]) idx = IW'(i);
  end

  assign rel_o  = (pend_q != '0 && cnt_q == '0) ? (NB'(1) << idx) : '0;
  assign done_o = (pend_q & ~rel_o) == '0;

  always_comb begin
    pend_d = start_i ? mask_i : (pend_q & ~rel_o);
    cnt_d  = (start_i || cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_rst_boot_seq.sv
// soc_rst_boot_seq: PLL config handshake, lock wait with timeout, staged domain release, soft reset and PLL reconfiguration
module soc_rst_boot_seq
  import soc_rst_pkg::*;
#(
  parameter int                    NB_DOMAINS   = 3,
  parameter int                    CNT_WIDTH    = 8,
  parameter int                    RELEASE_DLY  = 16,
  parameter int                    LOCK_TIMEOUT = 200,
  parameter logic [NB_DOMAINS-1:0] SOFT_MASK    = NB_DOMAINS'(1),
  parameter int                    SOFT_HOLD    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_select_i,
  input  logic                  cpu_start_i,
  input  logic                  soft_reset_i,
  input  logic [31:0]           pll_cfg_i,
  input  logic                  pll_cfg_req_i,
  output logic [31:0]           pll_config_o,
  output logic                  pll_config_valid_o,
  input  logic                  pll_config_ready_i,
  input  logic                  pll_lock_i,
  output logic [NB_DOMAINS-1:0] rstn_o,
  output logic                  fetch_enable_o,
  output logic                  busy_o,
  output logic                  lock_timeout_o,
  output logic [2:0]            state_o
);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [31:0]             cfg_q, cfg_d;
  logic                    valid_q, valid_d;
  logic [NB_DOMAINS-1:0]   rstn_q, rstn_d;
  logic                    fe_q, fe_d;
  logic                    to_q, to_d;
  logic                    soft_q, soft_d;
  logic                    start;
  logic [NB_DOMAINS-1:0]   rel;
  logic                    done;

  assign start = (state_d == RELEASE) && (state_q != RELEASE);

  rst_release_chain #(
    .NB          (NB_DOMAINS),
    .CNT_WIDTH   (CNT_WIDTH),
    .RELEASE_DLY (RELEASE_DLY)
  ) u_chain (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .mask_i  (~rstn_q),
    .rel_o   (rel),
    .done_o  (done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    rstn_d  = rstn_q;
    fe_d    = 1'b0;
    to_d    = to_q;
    soft_d  = soft_q | soft_reset_i;
    case (state_q)
      IDLE: begin
        state_d = PLL_CFG;
        cfg_d   = pll_cfg_i;
        valid_d = 1'b1;
      end
      PLL_CFG: if (valid_q && pll_config_ready_i) begin
        valid_d = 1'b0;
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: if (pll_lock_i) begin
        state_d = RELEASE;
      end else if (cnt_q == CNT_WIDTH'(LOCK_TIMEOUT - 1)) begin
        to_d    = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        rstn_d  = rstn_q | rel;
        state_d = done ? RUN : RELEASE;
      end
      RUN: begin
        fe_d = boot_select_i | cpu_start_i;
        if (pll_cfg_req_i) begin
          state_d = HALT;
          fe_d    = 1'b0;
          soft_d  = 1'b0;
        end else if (soft_q) begin
          state_d = SOFT_RST;
          fe_d    = 1'b0;
          soft_d  = 1'b0;
          rstn_d  = rstn_q & ~SOFT_MASK;
          cnt_d   = '0;
        end
      end
      SOFT_RST: state_d = (cnt_q == CNT_WIDTH'(SOFT_HOLD - 1)) ? RELEASE : SOFT_RST;
      HALT: begin
        rstn_d  = '0;
        state_d = PLL_CFG;
        cfg_d   = pll_cfg_i;
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      rstn_q  <= '0;
      fe_q    <= 1'b0;
      to_q    <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      rstn_q  <= rstn_d;
      fe_q    <= fe_d;
      to_q    <= to_d;
      soft_q  <= soft_d;
    end
  end

  assign pll_config_o       = cfg_q;
  assign pll_config_valid_o = valid_q;
  assign rstn_o             = rstn_q;
  assign fetch_enable_o     = fe_q;
  assign busy_o             = state_q != RUN;
  assign lock_timeout_o     = to_q;
  assign state_o            = state_q;

endmodule
